// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the program counter, presents it to the
// instruction memory and registers the returned word for decode. Handles
// stalls, taken redirects and halts in FAULT on a misaligned redirect target
// or a pc beyond the end of instruction memory.
//
// Handshake: stall=1 means decode cannot accept a new instruction this cycle,
// so pc and the if_* registers hold; if_valid=1 marks if_instr/if_pc as a real
// instruction fetched from memory (never a bubble).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          SIZE     = 1024,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic        dbg_state_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    // Word-aligned reset pc and the memory depth as a 32-bit word index bound.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] SIZE_W           = 32'(SIZE);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        pc_in_range;

    assign pc_in_range = {2'b00, pc_q[31:2]} < SIZE_W;

    // Next-state logic: FAULT hold > redirect > range check > stall > fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_valid_d   = if_valid_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            RUN: begin
                if (redirect_en) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP;
                    if (redirect_addr[1:0] == 2'b00) begin
                        pc_d    = redirect_addr;
                        if_pc_d = 32'h0;
                    end else begin
                        // Misaligned target: pc stays where it was.
                        fault_d      = 1'b1;
                        fault_addr_d = redirect_addr;
                        state_d      = FAULT;
                    end
                end else if (!pc_in_range) begin
                    if_valid_d   = 1'b0;
                    if_instr_d   = NOP;
                    fault_d      = 1'b1;
                    fault_addr_d = pc_q;
                    state_d      = FAULT;
                end else if (!stall) begin
                    if_instr_d = imem_rd;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            FAULT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC_ALIGNED;
            if_instr_q   <= NOP;
            if_pc_q      <= 32'h0;
            if_valid_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_valid_q   <= if_valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, misaligned
// redirect fault, out-of-range fault (SIZE=4 instance), pc wrap-around
// (large-SIZE instance starting near the top of memory) and reset recovery.
module tb_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk;
    logic        rst, stall, redirect_en;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr, imem_rd, if_instr, if_pc, fault_addr;
    logic        if_valid, fault, dbg_state;

    // Second reset shared by the SIZE=4 and wrap-around instances.
    logic        rst_b;
    logic [31:0] s_imem_addr, s_imem_rd, s_if_instr, s_if_pc, s_fault_addr;
    logic        s_if_valid, s_fault, s_dbg_state;
    logic [31:0] w_imem_addr, w_imem_rd, w_if_instr, w_if_pc, w_fault_addr;
    logic        w_if_valid, w_fault, w_dbg_state;

    int checks;
    int failures;

    // Memory model: word n holds value n.
    assign imem_rd   = {2'b00, imem_addr[31:2]};
    assign s_imem_rd = {2'b00, s_imem_addr[31:2]};
    assign w_imem_rd = {2'b00, w_imem_addr[31:2]};

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .fault(fault), .fault_addr(fault_addr), .dbg_state_o(dbg_state)
    );

    fetch_unit #(.SIZE(4)) dut_small (
        .clk(clk), .rst(rst_b), .stall(1'b0), .redirect_en(1'b0),
        .redirect_addr(32'h0), .imem_addr(s_imem_addr), .imem_rd(s_imem_rd),
        .if_instr(s_if_instr), .if_pc(s_if_pc), .if_valid(s_if_valid),
        .fault(s_fault), .fault_addr(s_fault_addr), .dbg_state_o(s_dbg_state)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFF8), .SIZE(1 << 30)) dut_wrap (
        .clk(clk), .rst(rst_b), .stall(1'b0), .redirect_en(1'b0),
        .redirect_addr(32'h0), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
        .if_instr(w_if_instr), .if_pc(w_if_pc), .if_valid(w_if_valid),
        .fault(w_fault), .fault_addr(w_fault_addr), .dbg_state_o(w_dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP_W || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_if: valid=%b instr=%h pc=%h expected 0/%h/0", if_valid, if_instr, if_pc, NOP_W);
        end
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0 || imem_addr !== 32'h0 || dbg_state !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: fault=%b fault_addr=%h imem_addr=%h state=%b expected 0/0/0/0", fault, fault_addr, imem_addr, dbg_state);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'(k) || imem_addr !== 32'(4 * k + 4)) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: valid=%b pc=%h instr=%h addr=%h expected 1/%h/%h/%h",
                         k, if_valid, if_pc, if_instr, imem_addr, 4 * k, k, 4 * k + 4);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        checks++;
        if (if_pc !== 32'h8 || if_instr !== 32'h2 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_setup: pc=%h instr=%h addr=%h expected 8/2/c", if_pc, if_instr, imem_addr);
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (if_pc !== 32'h8 || if_instr !== 32'h2 || if_valid !== 1'b1 || imem_addr !== 32'hC) begin
                failures++;
                $display("FAIL stall_hold[%0d]: pc=%h instr=%h valid=%b addr=%h expected 8/2/1/c", k, if_pc, if_instr, if_valid, imem_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (if_pc !== 32'hC || if_instr !== 32'h3 || if_valid !== 1'b1 || imem_addr !== 32'h10) begin
            failures++;
            $display("FAIL stall_resume: pc=%h instr=%h valid=%b addr=%h expected c/3/1/10", if_pc, if_instr, if_valid, imem_addr);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h40;
        step();
        stall = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP_W || if_pc !== 32'h0 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redirect_bubble: valid=%b instr=%h pc=%h addr=%h expected 0/%h/0/40", if_valid, if_instr, if_pc, imem_addr, NOP_W);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'd16 || imem_addr !== 32'h44) begin
            failures++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h addr=%h expected 1/40/10/44", if_valid, if_pc, if_instr, imem_addr);
        end
    endtask

    task automatic test_misaligned_fault();
        redirect_en = 1'b1; redirect_addr = 32'h42;
        step();
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h42 || if_valid !== 1'b0 || if_instr !== NOP_W || imem_addr !== 32'h44 || dbg_state !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_fault: fault=%b addr=%h valid=%b instr=%h pc=%h state=%b expected 1/42/0/%h/44/1",
                     fault, fault_addr, if_valid, if_instr, imem_addr, dbg_state, NOP_W);
        end
        for (int k = 0; k < 10; k++) begin
            redirect_en   = 1'($urandom_range(0, 1));
            stall         = 1'($urandom_range(0, 1));
            redirect_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            step();
            checks++;
            if (fault !== 1'b1 || fault_addr !== 32'h42 || if_valid !== 1'b0 || imem_addr !== 32'h44) begin
                failures++;
                $display("FAIL fault_hold[%0d]: fault=%b addr=%h valid=%b pc=%h expected 1/42/0/44", k, fault, fault_addr, if_valid, imem_addr);
            end
        end
    endtask

    task automatic test_reset_recovery();
        // Reset while in FAULT with stall and redirect also asserted.
        rst = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h43;
        step();
        rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        checks++;
        if (fault !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || fault_addr !== 32'h0 || dbg_state !== 1'b0) begin
            failures++;
            $display("FAIL reset_from_fault: fault=%b pc=%h valid=%b fault_addr=%h state=%b expected 0/0/0/0/0", fault, imem_addr, if_valid, fault_addr, dbg_state);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            failures++;
            $display("FAIL restart_after_fault: valid=%b pc=%h instr=%h expected 1/0/0", if_valid, if_pc, if_instr);
        end
        // Reset while stalled in RUN.
        step();
        stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        checks++;
        if (fault !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_instr !== NOP_W) begin
            failures++;
            $display("FAIL reset_mid_stall: fault=%b pc=%h valid=%b instr=%h expected 0/0/0/%h", fault, imem_addr, if_valid, if_instr, NOP_W);
        end
        step();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL restart_after_stall: valid=%b pc=%h instr=%h addr=%h expected 1/0/0/4", if_valid, if_pc, if_instr, imem_addr);
        end
    endtask

    task automatic test_out_of_range_and_wrap();
        logic [31:0] wrap_pc [3];
        wrap_pc[0] = 32'hFFFFFFF8;
        wrap_pc[1] = 32'hFFFFFFFC;
        wrap_pc[2] = 32'h00000000;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (s_if_valid !== 1'b1 || s_if_pc !== 32'(4 * k) || s_if_instr !== 32'(k) || s_fault !== 1'b0) begin
                failures++;
                $display("FAIL small_fetch[%0d]: valid=%b pc=%h instr=%h fault=%b expected 1/%h/%h/0", k, s_if_valid, s_if_pc, s_if_instr, s_fault, 4 * k, k);
            end
            if (k < 3) begin
                checks++;
                if (w_if_valid !== 1'b1 || w_if_pc !== wrap_pc[k] || w_if_instr !== {2'b00, wrap_pc[k][31:2]}) begin
                    failures++;
                    $display("FAIL wrap_fetch[%0d]: valid=%b pc=%h instr=%h expected 1/%h/%h", k, w_if_valid, w_if_pc, w_if_instr, wrap_pc[k], {2'b00, wrap_pc[k][31:2]});
                end
            end
        end
        step();
        checks++;
        if (s_fault !== 1'b1 || s_fault_addr !== 32'h10 || s_if_valid !== 1'b0 || s_if_instr !== NOP_W || s_imem_addr !== 32'h10) begin
            failures++;
            $display("FAIL small_range_fault: fault=%b addr=%h valid=%b instr=%h pc=%h expected 1/10/0/%h/10", s_fault, s_fault_addr, s_if_valid, s_if_instr, s_imem_addr, NOP_W);
        end
        step();
        checks++;
        if (s_fault !== 1'b1 || s_fault_addr !== 32'h10 || s_if_valid !== 1'b0) begin
            failures++;
            $display("FAIL small_range_hold: fault=%b addr=%h valid=%b expected 1/10/0", s_fault, s_fault_addr, s_if_valid);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; rst_b = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_addr = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned_fault();
        test_reset_recovery();
        test_out_of_range_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
